// File: rtl/sign_multiplier.sv
// Sequential shift-add multiplier with accumulate: product = multiplicand * multiplier + addend.
// One multiplier bit per cycle; signed (two's complement) or unsigned operands selected by sign.
module sign_multiplier #(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INPUT_BIT_WIDTH-1:0]     multiplicand,
  input  logic [INPUT_BIT_WIDTH-1:0]     multiplier,
  input  logic [INPUT_BIT_WIDTH-1:0]     addend,
  input  logic                           sign,
  output logic                           ready,
  output logic [2*INPUT_BIT_WIDTH-1:0]   product
);

  localparam int N  = INPUT_BIT_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t          state;
  logic [N-1:0]    mcand_mag;
  logic [N-1:0]    mplier_sh;
  logic [N-1:0]    addend_q;
  logic            sign_q;
  logic            neg_q;
  logic [2*N-1:0]  acc;
  logic [CW-1:0]   count;

  logic [N-1:0]    mag_a;
  logic [N-1:0]    mag_b;
  logic            neg_in;
  logic [2*N-1:0]  partial;
  logic [2*N-1:0]  signed_acc;
  logic [2*N-1:0]  addend_ext;

  // Magnitudes fit in N unsigned bits, including |-2^(N-1)| = 2^(N-1).
  always_comb begin
    mag_a      = (sign && multiplicand[N-1]) ? -multiplicand : multiplicand;
    mag_b      = (sign && multiplier[N-1])   ? -multiplier   : multiplier;
    neg_in     = sign & (multiplicand[N-1] ^ multiplier[N-1]);
    partial    = {{N{1'b0}}, mcand_mag} << count;
    signed_acc = neg_q ? -acc : acc;
    addend_ext = sign_q ? {{N{addend_q[N-1]}}, addend_q} : {{N{1'b0}}, addend_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      product   <= '0;
      acc       <= '0;
      count     <= '0;
      mcand_mag <= '0;
      mplier_sh <= '0;
      addend_q  <= '0;
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_mag <= mag_a;
            mplier_sh <= mag_b;
            addend_q  <= addend;
            sign_q    <= sign;
            neg_q     <= neg_in;
            acc       <= '0;
            count     <= '0;
            ready     <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (mplier_sh[0]) begin
            acc <= acc + partial;
          end
          mplier_sh <= mplier_sh >> 1;
          if (count == LAST_BIT) begin
            state <= FINISH;
          end else begin
            count <= count + 1'b1;
          end
        end
        FINISH: begin
          product <= signed_acc + addend_ext;
          ready   <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_multiplier.sv
// Self-checking bench for sign_multiplier: a cycle-level behavioural model is compared
// against ready/product on every falling edge, plus directed literal checks.
module tb_sign_multiplier;

  localparam int N = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   addend;
  logic           sign;
  logic           ready;
  logic [2*N-1:0] product;

  int passCount  = 0;
  int checkCount = 0;

  sign_multiplier #(.INPUT_BIT_WIDTH(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .sign         (sign),
    .ready        (ready),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic straight from the definition, wrapped to 2N bits.
  function automatic logic [2*N-1:0] refProduct(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic [N-1:0] c, input logic sg);
    longint va, vb, vc, r;
    va = sg ? longint'($signed(a)) : longint'(a);
    vb = sg ? longint'($signed(b)) : longint'(b);
    vc = sg ? longint'($signed(c)) : longint'(c);
    r  = va * vb + vc;
    return (2*N)'(r);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Cycle-level model: busy for N+1 edges after an accepted start, then the result appears.
  logic           modelValid = 1'b0;
  logic           expReady;
  logic [2*N-1:0] expProduct;
  logic [2*N-1:0] pending;
  int             busyLeft;

  always @(posedge clk) begin
    if (reset) begin
      expReady   = 1'b1;
      expProduct = '0;
      busyLeft   = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          expReady   = 1'b1;
          expProduct = pending;
        end
      end else if (start) begin
        pending  = refProduct(multiplicand, multiplier, addend, sign);
        busyLeft = N + 1;
        expReady = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cycle_ready", longint'(ready), longint'(expReady));
      checkOutput("cycle_product", longint'(product), longint'(expProduct));
    end
  end

  // Runs one operation; operands are scrambled right after start is sampled.
  task automatic applyStimulus(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] c, input logic sg, output logic [2*N-1:0] res);
    int cycles;
    cycles = 0;
    while (!ready && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    sign         = sg;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = N'($urandom);
    addend       = N'($urandom);
    sign         = 1'($urandom);
    cycles = 0;
    while (!ready && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({name, "_busy_cycles"}, cycles, N + 1);
    res = product;
  endtask

  logic [2*N-1:0] res;
  int cycles;

  initial begin
    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0; addend = '0; sign = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_ready", longint'(ready), 1);
    checkOutput("reset_product", longint'(product), 0);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("model_unsigned", longint'(refProduct(8'd13, 8'd2, 8'd1, 1'b0)), 27);
    checkOutput("model_signed", longint'(refProduct(8'hF3, 8'd2, 8'hFF, 1'b1)), 'hFFE5);

    applyStimulus("u13x2", 8'd13, 8'd2, 8'd1, 1'b0, res);
    checkOutput("u13x2", longint'(res), 27);
    applyStimulus("umax", 8'd255, 8'd255, 8'd255, 1'b0, res);
    checkOutput("umax", longint'(res), 'hFF00);
    applyStimulus("s_neg13x2", 8'hF3, 8'd2, 8'hFF, 1'b1, res);
    checkOutput("s_neg13x2", longint'(res), 'hFFE5);
    applyStimulus("s_min_sq", 8'h80, 8'h80, 8'h7F, 1'b1, res);
    checkOutput("s_min_sq", longint'(res), 'h407F);

    applyStimulus("rt13", 8'd6, 8'd2, 8'd1, 1'b0, res);
    checkOutput("rt13", longint'(res), 13);
    applyStimulus("rt69", 8'd1, 8'd42, 8'd27, 1'b0, res);
    checkOutput("rt69", longint'(res), 69);
    applyStimulus("rt255", 8'd51, 8'd5, 8'd0, 1'b0, res);
    checkOutput("rt255", longint'(res), 255);
    applyStimulus("rt77", 8'd77, 8'd1, 8'd0, 1'b0, res);
    checkOutput("rt77", longint'(res), 77);
    applyStimulus("rt150", 8'd1, 8'd150, 8'd0, 1'b0, res);
    checkOutput("rt150", longint'(res), 150);

    applyStimulus("zero", 8'd0, 8'd200, 8'd0, 1'b0, res);
    checkOutput("zero", longint'(res), 0);
    applyStimulus("ident", 8'd77, 8'd1, 8'd0, 1'b1, res);
    checkOutput("ident", longint'(res), 77);

    // Start pulsed mid-run with other operands must be ignored.
    multiplicand = 8'd13; multiplier = 8'd2; addend = 8'd1; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    multiplicand = 8'd99; multiplier = 8'd77; addend = 8'd5; sign = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 4;
    while (!ready && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("ignored_start_busy", cycles, N + 1);
    checkOutput("ignored_start_product", longint'(product), 27);

    // Reset four cycles in, coinciding with a start request.
    multiplicand = 8'd100; multiplier = 8'd100; addend = 8'd3; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    checkOutput("abort_ready", longint'(ready), 1);
    checkOutput("abort_product", longint'(product), 0);
    applyStimulus("after_abort", 8'd3, 8'd3, 8'd0, 1'b0, res);
    checkOutput("after_abort", longint'(res), 9);

    // Start held high: back-to-back operations, checked by the per-cycle model.
    start = 1'b1;
    for (int i = 0; i < 4 * (N + 2); i++) begin
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      addend       = N'($urandom);
      sign         = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    cycles = 0;
    while (!ready && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("held_start_drain", longint'(ready), 1);

    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] ra, rb, rc;
      logic rs;
      ra = N'($urandom); rb = N'($urandom); rc = N'($urandom); rs = 1'($urandom);
      if (i % 10 == 0) ra = 8'h80;
      if (i % 10 == 1) rb = 8'hFF;
      applyStimulus("rand", ra, rb, rc, rs, res);
      checkOutput("rand_result", longint'(res), longint'(refProduct(ra, rb, rc, rs)));
    end

    @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
